// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the Thumb instruction fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [7:0]  BKPT_OPC     = 8'hBE;
    localparam int          PC_INC       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Brief   : Registered head-of-queue FIFO of {instr, pc} entries; flush wins.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Thumb halfword fetch with prefetch FIFO and branch redirect.
//           Optional BKPT halt enabled by defining FETCH_BKPT_HALT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_rvalid,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 16 + ADDR_W;

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] pc_next;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              room_after;
    logic              chain;
    logic              bkpt_hit;
    logic              halt_q;

    assign pc_next    = fetch_pc + ADDR_W'(PC_INC);
    assign pop        = instr_valid && instr_ready && !redirect;
    assign push       = (state == WAIT) && imem_rvalid && !redirect;
    assign room_after = pop ? (count < CW'(FIFO_DEPTH)) : (count < CW'(FIFO_DEPTH - 1));

`ifdef FETCH_BKPT_HALT_EN
    assign bkpt_hit = (imem_rdata[15:8] == BKPT_OPC);
    assign halted   = halt_q;
`else
    assign bkpt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Back-to-back: the next request is presented in the response cycle itself.
    assign chain     = push && !bkpt_hit && room_after;
    assign imem_req  = ((state == WAIT) && (!imem_rvalid || chain)) ||
                       ((state == DROP) && !imem_rvalid);
    assign imem_addr = chain ? pc_next : req_addr;

    assign instr       = head[EW-1:ADDR_W];
    assign instr_pc    = head[ADDR_W-1:0];
    assign instr_valid = !empty;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({imem_rdata, req_addr}),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            halt_q   <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(1);
            halt_q   <= 1'b0;
            if (state == WAIT && !imem_rvalid) begin
                state <= DROP;
            end else if (imem_rvalid) begin
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < CW'(FIFO_DEPTH) && !halt_q) begin
                        state    <= WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        fetch_pc <= pc_next;
                        if (bkpt_hit) begin
                            halt_q <= 1'b1;
                        end
                        if (chain) begin
                            req_addr <= pc_next;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that produces the 16-bit Thumb instruction stream consumed by the decode block.
- Issues halfword reads to instruction memory and buffers returned halfwords, each with its address, in a small prefetch FIFO.
- Presents them to decode under a valid/ready handshake.
- Redirects the stream on taken branches from execute, discarding stale in-flight and buffered instructions.

Parameters:
- ADDR_W, 16, byte address width of the PC and memory address.
- RESET_PC, 16'h0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  read request; held high until imem_rvalid.
- imem_addr  out  ADDR_W  halfword-aligned read address; stable while imem_req is high.
- imem_rdata  in  16  returned halfword.
- imem_rvalid  in  1  one-cycle response strobe, arriving at least 1 cycle after the request.
- redirect  in  1  taken branch or PC write from execute.
- redirect_pc  in  ADDR_W  new fetch address.
- instr  out  16  instruction to decode.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the head this cycle.
- halted  out  1  fetch stopped (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (reset==0 at a clock edge):
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr=16'h0000, instr_pc=0, instr_valid=0, halted=0.
  - Internal: FIFO emptied, fetch_pc=RESET_PC, state=IDLE, drop flag cleared.
  - imem_rvalid is ignored while in reset; the memory shares this reset, so no stale response survives it.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: an outstanding response must be discarded.
- IDLE to WAIT: when (fifo_count + 0) < FIFO_DEPTH and no redirect is present, assert imem_req with imem_addr=fetch_pc. The first request goes out in the first cycle after reset releases.
- WAIT, on imem_rvalid:
  - Push {imem_rdata, imem_addr} into the FIFO and set fetch_pc += 2; the addition wraps modulo 2^ADDR_W.
  - If the FIFO still has room after the push, issue the next request in the same cycle (back-to-back); otherwise go to IDLE.
  - At most one request is outstanding at any time.
- Redirect (highest priority):
  - FIFO is flushed and instr_valid goes to 0 the next cycle.
  - fetch_pc = {redirect_pc[ADDR_W-1:1],1'b0}; bit 0 is forced to 0.
  - If in IDLE: a request to the new pc is issued the next cycle.
  - If in WAIT with no rvalid this cycle: go to DROP. Keep imem_req high until the stale response arrives and discard it, then request the new pc the next cycle.
  - If rvalid coincides with the redirect: discard that response and request the new pc the next cycle.
  - A redirect while in DROP only updates fetch_pc.
  - If pop and redirect coincide, the pop is ignored; the entry is flushed and counts as not consumed.
- Handshake and FIFO:
  - A transfer occurs when instr_valid && instr_ready.
  - instr and instr_pc are FIFO head outputs; they hold stable while valid and not ready.
  - Latency: the first instruction after reset or redirect appears 1 cycle after its imem_rvalid.
  - A push and a pop in the same cycle keep the count unchanged.
  - A push into a full FIFO is impossible by construction; assert it in simulation.
  - The FIFO is registered and head-of-queue.
- Throughput: one instruction per cycle when memory returns data 1 cycle after the request and decode is always ready.

Optional Feature:
- Macro: FETCH_BKPT_HALT_EN.
- When defined:
  - A pushed halfword with [15:8]==8'hBE (Thumb BKPT) is still delivered to decode.
  - After that push, no new requests are issued and halted=1.
  - A redirect or reset clears halted and resumes fetch.
- When undefined: BKPT is an ordinary halfword and halted is tied to 0.

Decomposition:
- Shared package fetch_pkg holds:
  - Defaults for ADDR_W and RESET_PC.
  - Constant BKPT_OPC=8'hBE.
  - Fetch state enum: IDLE, WAIT, DROP.
  - Halfword PC increment constant 2.
- Sub-module fetch_fifo: parameterised synchronous FIFO of {instr, pc} entries with push, pop, flush, count, full and empty. flush has priority over push and pop.

Test Plan:
- Reset, memory latency 1, ready held high, memory holding 16'h2005, 16'h3103, 16'hE7FE at 0/2/4 -> instr_pc sequence 0, 2, 4 on consecutive cycles; instr matches.
- instr_ready low for 5 cycles -> at most 2 entries buffered, imem_req stops, head stable; on release, in-order delivery with no loss or duplicate.
- Redirect to 16'h0041 while a request is outstanding, latency 3 -> stale response discarded; next request address 16'h0040; first instr_pc after redirect = 16'h0040.
- Redirect in the same cycle as imem_rvalid and a pop -> none of the old data reaches decode; FIFO empty the next cycle.
- fetch_pc=16'hFFFE -> next fetch address 16'h0000.
- reset low mid-WAIT, then released -> all outputs at reset values; first request to RESET_PC. With FETCH_BKPT_HALT_EN defined: 16'hBE00 delivered, halted=1, no further imem_req until a redirect.
